// File: rtl/vga_framebuffer_reader.sv
// rtl/vga_framebuffer_reader.sv - 640x480@60 scan-out of a 40x30 one-bit cell framebuffer
module vga_framebuffer_reader #(
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33
) (
  input  logic          CLOCK_50,
  input  logic          reset_button,
  input  logic [1199:0] framebuffer,
  output logic [3:0]    red_out,
  output logic [3:0]    green_out,
  output logic [3:0]    blue_out,
  output logic          h_sync_out,
  output logic          v_sync_out,
  output logic          frame_start
);

  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] H_SBEG  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SEND  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] V_SBEG  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SEND  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic          pix_en;
  logic [9:0]    h_count;
  logic [9:0]    v_count;
  logic [1199:0] shadow;

  logic [10:0]   cell_idx;
  logic          cell_bit;
  logic          active;
  logic [11:0]   pixel;

  assign cell_idx = 11'(v_count[8:4]) * 11'd40 + 11'(h_count[9:4]);
  // Blanking positions can form indices past the array; those never reach the outputs.
  assign cell_bit = (cell_idx < 11'd1200) ? shadow[cell_idx] : 1'b0;
  assign active   = (h_count < H_VIS) && (v_count < V_VIS);
  assign pixel    = active ? (cell_bit ? FG_COLOR : BG_COLOR) : 12'h000;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_button) begin
      pix_en      <= 1'b0;
      h_count     <= '0;
      v_count     <= '0;
      shadow      <= '0;
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
      h_sync_out  <= 1'b1;
      v_sync_out  <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= 1'b0;
      if (pix_en) begin
        red_out    <= pixel[11:8];
        green_out  <= pixel[7:4];
        blue_out   <= pixel[3:0];
        h_sync_out <= !((h_count >= H_SBEG) && (h_count <= H_SEND));
        v_sync_out <= !((v_count >= V_SBEG) && (v_count <= V_SEND));
        // Capture at the top of vertical blanking so game writes never tear a frame.
        if (h_count == 10'd0 && v_count == V_VIS)
          shadow <= framebuffer;
        if (h_count == H_LAST) begin
          h_count <= '0;
          if (v_count == V_LAST) begin
            v_count     <= '0;
            frame_start <= 1'b1;
          end else begin
            v_count <= v_count + 10'd1;
          end
        end else begin
          h_count <= h_count + 10'd1;
        end
      end
    end
  end

endmodule

// File: doc/vga_framebuffer_reader.md
# vga_framebuffer_reader

Scan-out engine that consumes the 1200-bit character-cell framebuffer written by the game display logic and drives the DE0 VGA connector. Generates 640x480@60 Hz timing from CLOCK_50 using a divide-by-2 pixel enable, with each framebuffer bit mapped to a 16x16-pixel cell (40 columns x 30 rows). A shadow copy of the framebuffer is latched once per frame at the start of vertical blanking, so game-side writes never tear the visible image.

## Interface
- FG_COLOR, 12'hFFF, {R,G,B} 4 bits each, colour of a set cell
- BG_COLOR, 12'h000, {R,G,B} 4 bits each, colour of a clear cell in the active area
- CLOCK_50  in  1  50 MHz system clock, all logic on rising edge
- reset_button  in  1  synchronous, active-low reset
- framebuffer  in  1200  bit index = row*40 + col; row 0 is top, col 0 is left
- red_out  out  4  red level, registered
- green_out  out  4  green level, registered
- blue_out  out  4  blue level, registered
- h_sync_out  out  1  horizontal sync, active low, registered
- v_sync_out  out  1  vertical sync, active low, registered
- frame_start  out  1  one-CLOCK_50 pulse when counters wrap to (0,0)

## Operation
- pix_en toggles every CLOCK_50 cycle; it is 0 in the first cycle after reset. All counters and outputs advance only on cycles with pix_en=1.
- h_count 0..799: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799. Wraps 799->0 and increments v_count.
- v_count 0..524: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524. Wraps 524->0.
- Active when h_count<640 and v_count<480. Cell col = h_count[9:4], row = v_count[8:4], bit = shadow[row*40+col]. The index is formed in 11-bit unsigned arithmetic, and 39*... max 1199 stays in range.
- Active pixel: bit=1 gives FG_COLOR, bit=0 gives BG_COLOR. Outside the active area, RGB = 0 regardless of parameters.
- h_sync_out=0 iff 656<=h_count<=751. v_sync_out=0 iff 490<=v_count<=491.
- Shadow latch: on the pix_en cycle where h_count==0 and v_count==480, shadow <= framebuffer. This is the only capture point; framebuffer changes at any other time are invisible until then.
- frame_start=1 for exactly the one CLOCK_50 cycle following the pix_en edge where counters go (799,524)->(0,0). It is 0 otherwise.
- Reset (reset_button=0 sampled on a clock edge), takes priority over everything, including mid-line and mid-frame:
  - h_count=0, v_count=0, pix_en=0, shadow=0.
  - RGB=0, h_sync_out=1, v_sync_out=1, frame_start=0.
  - Scan restarts at pixel (0,0) of a blank frame.

## Timing
- Outputs for pixel (h,v) are computed from the counter values at the pix_en edge where the counters equal (h,v). They appear after that edge, the counters advance on the same edge, and the outputs hold for 2 CLOCK_50 cycles. RGB and both syncs are therefore mutually aligned, with 1 pixel of latency.
- Line = 1600 CLOCK_50 cycles; h_sync low for 192 cycles. Frame = 525 lines = 840000 cycles; v_sync low for 3200 cycles.
- Shadow update takes effect on the next visible line that reads it (v_count=0 of the following frame). No combinational path exists from framebuffer to the outputs.
- After reset deassertion, the first pix_en=1 cycle is the 2nd edge. The first visible frame shows all-BG; framebuffer content is first displayed in frame 2.

## Test plan
- Reset: hold reset_button=0 for 5 cycles with random framebuffer. Required: RGB=0, syncs=1, frame_start=0 throughout; h_count=0 at the first pix_en after release.
- H/V timing: free-run 2 frames. Required: h_sync period 1600 cycles with 192 low; v_sync period 840000 with 3200 low; frame_start period 840000 and 1 cycle wide.
- Mapping: framebuffer bit 0 and bit 1199 set, FG=12'hF00, BG=12'h00F, run 2 frames. Required in frame 2: red at x 0-15, y 0-15 and x 624-639, y 464-479; blue in all other active pixels; RGB=0 in blanking.
- Anti-tear: in frame 2, set bit 41 at v_count=100. Required: cell (row1,col1) stays BG for the rest of the frame and shows FG from frame 3.
- Mid-frame reset: assert reset at v_count=300, h_count=400 for 1 cycle. Required: outputs return to reset values next cycle; the next frame is all-BG; the frame after that shows framebuffer contents.
- Boundary pixels: all bits set. Required: FG at h=639, RGB=0 at h=640; FG on line 479, RGB=0 on line 480.
